// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the load/store unit (master) and the RV64 data memory (slave).
// One request per transaction: valid/ready request phase, then a single valid response.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [7:0]        mem_wmask;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: turns one MEM-stage load/store into a single aligned 64-bit bus
// transaction, lane-shifts store data, aligns and extends load data, stalls the pipeline
// while busy and converts a hung bus into an error via a watchdog.
// Optional: define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned H/W/D accesses without
// touching the bus; otherwise misaligned accesses are truncated to the doubleword.
module mem_access_unit #(
  parameter int unsigned ADDR_W         = 64,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_is_store,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        mask_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic              store_q;
  logic [7:0]        cnt_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic [7:0]        base_mask;
  logic [7:0]        lane_mask;
  logic              misalign;
  logic              expire;
  logic [DATA_W-1:0] raw;
  logic [DATA_W-1:0] load_ext;

  // Watchdog fires on the TIMEOUT_CYCLES-th WAIT cycle (counter starts at 0 on handshake).
  assign expire = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  // Byte strobes for the incoming request; lanes past byte 7 fall off the top.
  always_comb begin
    base_mask = 8'hFF;
    case (req_size)
      2'd0:    base_mask = 8'h01;
      2'd1:    base_mask = 8'h03;
      2'd2:    base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
    lane_mask = base_mask << req_addr[2:0];
  end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  // Natural-alignment check for the incoming request.
  always_comb begin
    misalign = 1'b0;
    case (req_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = req_addr[0];
      2'd2:    misalign = |req_addr[1:0];
      default: misalign = |req_addr[2:0];
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Align the response doubleword to the accessed byte, truncate and extend.
  always_comb begin
    raw      = bus.mem_rsp_rdata >> {addr_q[2:0], 3'b000};
    load_ext = raw;
    case (size_q)
      2'd0:    load_ext = signed_q ? {{56{raw[7]}}, raw[7:0]}   : {56'b0, raw[7:0]};
      2'd1:    load_ext = signed_q ? {{48{raw[15]}}, raw[15:0]} : {48'b0, raw[15:0]};
      2'd2:    load_ext = signed_q ? {{32{raw[31]}}, raw[31:0]} : {32'b0, raw[31:0]};
      default: load_ext = raw;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req_valid) state_d = misalign ? StResp : StReq;
      StReq:   if (bus.mem_req_ready) state_d = StWait;
      StWait:  if (bus.mem_rsp_valid || expire) state_d = StResp;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; the pipeline is released in the RESP cycle.
  always_comb begin
    stall             = 1'b0;
    done              = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_we        = 1'b0;
    case (state_q)
      StIdle:  stall = req_valid;
      StReq: begin
        stall             = 1'b1;
        bus.mem_req_valid = 1'b1;
        bus.mem_we        = store_q;
      end
      StWait:  stall = 1'b1;
      default: done  = 1'b1;
    endcase
  end

  // Request latch, watchdog counter and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      store_q  <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata << {req_addr[2:0], 3'b000};
            mask_q   <= req_is_store ? lane_mask : 8'h00;
            size_q   <= req_size;
            signed_q <= req_signed;
            store_q  <= req_is_store;
            err_q    <= misalign;
            if (misalign) rdata_q <= '0;
          end
        end
        StReq: begin
          if (bus.mem_req_ready) cnt_q <= '0;
        end
        StWait: begin
          if (bus.mem_rsp_valid) begin
            rdata_q <= store_q ? '0 : load_ext;
            err_q   <= 1'b0;
          end else if (expire) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr  = {addr_q[ADDR_W-1:3], 3'b000};
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wmask = mask_q;
  assign rdata         = rdata_q;
  assign err           = done && err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: expected {rdata, err} pushed to a scoreboard at
// issue time and popped when done pulses; bus-side signals checked cycle by cycle.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_is_store, req_signed;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        stall, done, err;
  logic [63:0] rdata;

  int total = 0;
  int bad   = 0;
  logic [64:0] sb[$];

  mem_access_unit_if bus_if ();

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_is_store (req_is_store),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .stall        (stall),
    .done         (done),
    .rdata        (rdata),
    .err          (err),
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard pop on every done pulse.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 64'(done), 64'd0);
      end else begin
        logic [64:0] e;
        e = sb.pop_front();
        check_eq("sb_rdata", rdata, e[64:1]);
        check_eq("sb_err", 64'(err), 64'(e[0]));
      end
    end
  end

  // One bus transaction: rdy_lat cycles of backpressure, response rsp_lat WAIT cycles after
  // the handshake (-1 = never). exp_n is the number of WAIT cycles seen before done.
  task automatic do_op(input string tag, input logic st, input logic [63:0] a, input logic [63:0] wd,
                       input logic [1:0] sz, input logic sg, input int rdy_lat, input int rsp_lat,
                       input logic [63:0] rd, input logic [63:0] exp_rd, input logic exp_er,
                       input logic [7:0] exp_mask, input logic [63:0] exp_wd, input int exp_n);
    int n;
    sb.push_back({exp_rd, exp_er});
    req_valid = 1'b1; req_is_store = st; req_addr = a; req_wdata = wd;
    req_size = sz; req_signed = sg;
    @(negedge clk);
    check_eq({tag, "_stall_issue"}, 64'(stall), 64'd1);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i <= rdy_lat; i++) begin
      bus_if.mem_req_ready = (i == rdy_lat);
      @(negedge clk);
      check_eq({tag, "_req_valid"}, 64'(bus_if.mem_req_valid), 64'd1);
      check_eq({tag, "_addr"}, bus_if.mem_addr, a & ~64'h7);
      check_eq({tag, "_wmask"}, 64'(bus_if.mem_wmask), 64'(exp_mask));
      check_eq({tag, "_we"}, 64'(bus_if.mem_we), 64'(st));
      check_eq({tag, "_stall_req"}, 64'(stall), 64'd1);
      if (st) check_eq({tag, "_wdata"}, bus_if.mem_wdata, exp_wd);
      tick();
    end
    bus_if.mem_req_ready = 1'b0;
    if (rsp_lat >= 0) begin
      repeat (rsp_lat) tick();
      bus_if.mem_rsp_valid = 1'b1;
      bus_if.mem_rsp_rdata = rd;
      tick();
      bus_if.mem_rsp_valid = 1'b0;
    end
    n = 0;
    @(negedge clk);
    while (!done && n < 400) begin
      n++;
      tick();
      @(negedge clk);
    end
    check_eq({tag, "_wait_cycles"}, 64'(n), 64'(exp_n));
    check_eq({tag, "_done"}, 64'(done), 64'd1);
    check_eq({tag, "_stall_resp"}, 64'(stall), 64'd0);
    tick();
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_is_store = 1'b0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; req_size = '0;
    bus_if.mem_req_ready = 1'b0;
    bus_if.mem_rsp_valid = 1'b0;
    bus_if.mem_rsp_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", 64'(stall), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_req_valid", 64'(bus_if.mem_req_valid), 64'd0);
    check_eq("rst_rdata", rdata, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Signed LW at offset 4: done 3 cycles after req_valid.
    do_op("lw_s", 1'b0, 64'h8000_0004, 64'h0, 2'd2, 1'b1, 0, 0, 64'h8000_0001_0000_0000,
          64'hFFFF_FFFF_8000_0001, 1'b0, 8'h00, 64'h0, 0);
    do_op("lw_u", 1'b0, 64'h8000_0004, 64'h0, 2'd2, 1'b0, 0, 0, 64'h8000_0001_0000_0000,
          64'h0000_0000_8000_0001, 1'b0, 8'h00, 64'h0, 0);
    do_op("lb_s", 1'b0, 64'h7, 64'h0, 2'd0, 1'b1, 0, 2, 64'h8011_2233_4455_6677,
          64'hFFFF_FFFF_FFFF_FF80, 1'b0, 8'h00, 64'h0, 0);
    do_op("lb_u", 1'b0, 64'h7, 64'h0, 2'd0, 1'b0, 0, 0, 64'h8011_2233_4455_6677,
          64'h0000_0000_0000_0080, 1'b0, 8'h00, 64'h0, 0);
    do_op("lh_s", 1'b0, 64'h2, 64'h0, 2'd1, 1'b1, 0, 1, 64'h0000_0000_F00D_0000,
          64'hFFFF_FFFF_FFFF_F00D, 1'b0, 8'h00, 64'h0, 0);
    do_op("sb", 1'b1, 64'h8000_0003, 64'hAB, 2'd0, 1'b0, 0, 0, 64'hDEAD_BEEF_DEAD_BEEF,
          64'h0, 1'b0, 8'h08, 64'h0000_0000_AB00_0000, 0);
    do_op("sd", 1'b1, 64'h10, 64'h1122_3344_5566_7788, 2'd3, 1'b0, 0, 0, 64'h0,
          64'h0, 1'b0, 8'hFF, 64'h1122_3344_5566_7788, 0);
    // Backpressure: ready low for 5 cycles, signed flag ignored for D.
    do_op("ld_bp", 1'b0, 64'h8000_0010, 64'h0, 2'd3, 1'b1, 5, 0, 64'h8123_4567_89AB_CDEF,
          64'h8123_4567_89AB_CDEF, 1'b0, 8'h00, 64'h0, 0);
    // Watchdog expiry, then a response on the 255th WAIT cycle.
    do_op("tmo", 1'b0, 64'h40, 64'h0, 2'd3, 1'b0, 0, -1, 64'h0,
          64'h0, 1'b1, 8'h00, 64'h0, 255);
    do_op("tmo_edge", 1'b0, 64'h40, 64'h0, 2'd3, 1'b0, 0, 254, 64'h55,
          64'h55, 1'b0, 8'h00, 64'h0, 0);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    // Misaligned LH traps without a bus request.
    sb.push_back({64'h0, 1'b1});
    req_valid = 1'b1; req_is_store = 1'b0; req_addr = 64'h1; req_size = 2'd1; req_signed = 1'b1;
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("mis_req_valid", 64'(bus_if.mem_req_valid), 64'd0);
    check_eq("mis_done", 64'(done), 64'd1);
    tick();
    tick();
`else
    // Misaligned accesses proceed; lanes past byte 7 are dropped.
    do_op("lh_mis", 1'b0, 64'h1, 64'h0, 2'd1, 1'b1, 0, 0, 64'h0000_0000_0012_3400,
          64'h0000_0000_0000_1234, 1'b0, 8'h00, 64'h0, 0);
    do_op("sh_mis", 1'b1, 64'h1, 64'hBEEF, 2'd1, 1'b0, 0, 0, 64'h0,
          64'h0, 1'b0, 8'h06, 64'h0000_0000_00BE_EF00, 0);
    do_op("sw_trunc", 1'b1, 64'h6, 64'h1122_3344, 2'd2, 1'b0, 0, 0, 64'h0,
          64'h0, 1'b0, 8'hC0, 64'h3344_0000_0000_0000, 0);
`endif

    // Reset while waiting for a response: outputs clear at once, late response ignored.
    req_valid = 1'b1; req_is_store = 1'b1; req_addr = 64'h108; req_wdata = 64'h77;
    req_size = 2'd3; req_signed = 1'b0;
    tick();
    req_valid = 1'b0;
    bus_if.mem_req_ready = 1'b1;
    tick();
    bus_if.mem_req_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_stall", 64'(stall), 64'd0);
    check_eq("arst_req_valid", 64'(bus_if.mem_req_valid), 64'd0);
    check_eq("arst_addr", bus_if.mem_addr, 64'h0);
    check_eq("arst_wdata", bus_if.mem_wdata, 64'h0);
    check_eq("arst_wmask", 64'(bus_if.mem_wmask), 64'h0);
    check_eq("arst_rdata", rdata, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    bus_if.mem_rsp_valid = 1'b1;
    tick();
    bus_if.mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("arst_no_done", 64'(done), 64'd0);
      tick();
    end

    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit between the MEM stage decode (rd_buf_flag, wmask, expand_signed, ALU address) and the RV64 data memory port.
- Converts one load/store per request into a single aligned 64-bit bus transaction with valid/ready request and valid response.
- Byte-lane shifts store data and builds the write mask.
- Aligns and sign/zero-extends load data for the MEM/WB register.
- Holds the pipeline with a stall while a transaction is in flight; watchdog converts a hung bus into an error.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; fixed at 64, byte lanes = 8.
- TIMEOUT_CYCLES, 255, max cycles waiting for mem_rsp_valid before bus error; 8-bit counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  MEM stage presents a memory op this cycle
- req_is_store  in  1  1 = store, 0 = load
- req_addr  in  64  byte address (ALU result)
- req_wdata  in  64  store data, right-justified
- req_size  in  2  0 = B, 1 = H, 2 = W, 3 = D
- req_signed  in  1  1 = sign-extend load result, 0 = zero-extend
- stall  out  1  freeze upstream pipeline registers
- done  out  1  one-cycle pulse: op complete
- rdata  out  64  extended load data, valid with done
- err  out  1  one-cycle pulse with done: timeout or misalign
- mem_req_valid  out  1  bus request
- mem_req_ready  in  1  bus accepts request
- mem_we  out  1  write enable
- mem_addr  out  64  req_addr with [2:0] cleared
- mem_wdata  out  64  req_wdata shifted left by 8*addr[2:0]
- mem_wmask  out  8  byte strobes
- mem_rsp_valid  in  1  response/ack for the accepted request
- mem_rsp_rdata  in  64  aligned doubleword read data

Behaviour:
- Reset:
  - Async, asserts immediately regardless of clk.
  - state = IDLE; stall, done, err, mem_req_valid, mem_we = 0; rdata, mem_addr, mem_wdata = 0; mem_wmask = 0; timeout counter = 0.
  - Reset mid-transaction abandons the op; no done is produced.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - On req_valid, latch addr/size/signed/is_store/wdata.
  - Compute mask: size B = 0x01, H = 0x03, W = 0x0F, D = 0xFF, shifted left by addr[2:0].
  - Go to REQ.
  - stall = req_valid (combinational) so the issuing instruction is held in the same cycle.
- REQ:
  - mem_req_valid = 1; address, data and mask stay stable until mem_req_ready.
  - On handshake, clear the counter and go to WAIT.
  - No timeout in REQ.
- WAIT:
  - Counter increments each cycle.
  - On mem_rsp_valid: capture the load result, go to RESP.
  - When the counter reaches TIMEOUT_CYCLES without a response: go to RESP with err = 1 and rdata = 0.
  - mem_rsp_valid in the same cycle the counter hits the limit: the response wins, no error.
- RESP:
  - done = 1 for exactly one cycle; err valid with it; stall = 0 this cycle so the pipeline advances.
  - Next state: IDLE.
  - A new req_valid seen in RESP is not accepted until IDLE; latency is two cycles minimum between back-to-back ops.
- Stall: stall = 1 in REQ and WAIT, plus IDLE && req_valid.
- Load extension:
  - raw = mem_rsp_rdata >> (8*addr[2:0]).
  - Truncate raw to the size.
  - Extend to 64 per req_signed. Size D ignores req_signed.
  - Result held in rdata until the next done.
- Stores: rdata = 0 at done.
- Minimum op latency: request cycle + 1 cycle to REQ + bus latency + RESP cycle. With ready = 1 and response after 1 cycle, done rises 3 cycles after req_valid.
- mem_rsp_valid outside WAIT is ignored.

Optional Feature:
- Macro: MEM_ACCESS_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned access is H with addr[0] != 0, W with addr[1:0] != 0, or D with addr[2:0] != 0.
  - Such an access skips the bus: IDLE goes straight to RESP, done = 1, err = 1, rdata = 0, mem_req_valid never asserts.
- Undefined:
  - No check; the mask and shift are computed as normal.
  - Lanes past byte 7 are dropped; the access is truncated to the doubleword.

Test Plan:
- Load word, signed: addr 0x80000004, mem_rsp_rdata 0x8000_0001_0000_0000, ready = 1, response 1 cycle later -> mem_addr 0x80000000, mem_wmask 0x00, done at cycle 3, rdata 0xFFFF_FFFF_8000_0001, err = 0.
- Store byte: addr 0x80000003, wdata 0xAB -> mem_we = 1, mem_wmask 0x08, mem_wdata 0x0000_0000_AB00_0000, done pulse, rdata = 0.
- Backpressure: mem_req_ready low 5 cycles -> mem_req_valid and address/data/mask stable all 5 cycles, stall stays high, one done only.
- Timeout: accepted load, no mem_rsp_valid -> done + err after 255 WAIT cycles, rdata = 0; a response arriving on the 255th cycle -> err = 0.
- Reset in WAIT: rst pulsed -> all outputs 0 immediately; a following rsp_valid produces no done.
- Macro defined, LH at addr 0x1 -> no mem_req_valid, done + err next cycle; macro undefined -> bus access with mask 0x06.
